// File: rtl/jtframe_cen_meter_if.sv
// Bus bundle for jtframe_cen_meter: measurement request, sampled cen stream and results.
interface jtframe_cen_meter_if #(
  parameter int unsigned W = 10
);
  logic         cen;
  logic         start;
  logic [W-1:0] m;
  logic [W-1:0] n;
  logic         valid;
  logic         busy;
  logic         err;
  logic [W-1:0] min_gap;
  logic [W-1:0] max_gap;

  modport master (
    output cen, start, m,
    input  n, valid, busy, err, min_gap, max_gap
  );

  modport slave (
    input  cen, start, m,
    output n, valid, busy, err, min_gap, max_gap
  );
endinterface

// File: rtl/jtframe_cen_meter.sv
// Counts cen pulses over an m-cycle window and reports n/m plus min/max pulse spacing.
// Define JTFRAME_CEN_GAP_EN to build the gap tracker; otherwise gaps read as constants.
module jtframe_cen_meter #(
  parameter int unsigned W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jtframe_cen_meter_if.slave   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] win_q, win_d;
  logic [W-1:0] cyc_q, cyc_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] n_q, n_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;

  logic         accept_c;
  logic         meas_c;
  logic         last_c;
  logic [W-1:0] cnt_nx_c;

  assign accept_c = (state_q == ST_IDLE) && bus.start && (bus.m != '0);
  assign meas_c   = (state_q == ST_MEASURE);
  assign last_c   = meas_c && (cyc_q == win_q - W'(1));
  // Count can never pass m: one pulse per cycle at most.
  assign cnt_nx_c = cnt_q + W'(bus.cen);

  // Window sequencing, pulse count and result strobe
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (accept_c) begin
            win_d   = bus.m;
            cyc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_MEASURE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_MEASURE: begin
        cnt_d = cnt_nx_c;
        cyc_d = cyc_q + W'(1);
        if (last_c) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          n_d     = cnt_nx_c;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.n     = n_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

`ifdef JTFRAME_CEN_GAP_EN
  logic         seen_q, seen_d;
  logic [W-1:0] gap_q, gap_d;
  logic [W-1:0] wmin_q, wmin_d;
  logic [W-1:0] wmax_q, wmax_d;
  logic [W-1:0] min_gap_q, min_gap_d;
  logic [W-1:0] max_gap_q, max_gap_d;
  logic         gap_done_c;

  // gap_q holds the distance the next pulse would close; it starts at the first pulse.
  always_comb begin
    seen_d     = seen_q;
    gap_d      = gap_q;
    wmin_d     = wmin_q;
    wmax_d     = wmax_q;
    min_gap_d  = min_gap_q;
    max_gap_d  = max_gap_q;
    gap_done_c = meas_c && bus.cen && seen_q;
    if (accept_c) begin
      seen_d = 1'b0;
      gap_d  = '0;
      wmin_d = '1;
      wmax_d = '0;
    end else if (meas_c) begin
      if (bus.cen) begin
        seen_d = 1'b1;
        gap_d  = W'(1);
      end else if (seen_q && (gap_q != '1)) begin
        gap_d = gap_q + W'(1);
      end
      if (gap_done_c && (gap_q < wmin_q)) wmin_d = gap_q;
      if (gap_done_c && (gap_q > wmax_q)) wmax_d = gap_q;
      if (last_c) begin
        min_gap_d = wmin_d;
        max_gap_d = wmax_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q    <= 1'b0;
      gap_q     <= '0;
      wmin_q    <= '1;
      wmax_q    <= '0;
      min_gap_q <= '1;
      max_gap_q <= '0;
    end else begin
      seen_q    <= seen_d;
      gap_q     <= gap_d;
      wmin_q    <= wmin_d;
      wmax_q    <= wmax_d;
      min_gap_q <= min_gap_d;
      max_gap_q <= max_gap_d;
    end
  end

  assign bus.min_gap = min_gap_q;
  assign bus.max_gap = max_gap_q;
`else
  assign bus.min_gap = '1;
  assign bus.max_gap = '0;
`endif

endmodule

// File: tb/tb_jtframe_cen_meter.sv
// Directed vector bench for jtframe_cen_meter; gap expectations follow JTFRAME_CEN_GAP_EN.
module tb_jtframe_cen_meter;

  localparam int unsigned W = 10;
  localparam int ALL1 = 1023;

  localparam int MODE_ZERO = 0;
  localparam int MODE_ONE  = 1;
  localparam int MODE_FRAC = 2;
  localparam int MODE_EV4  = 3;
  localparam int MODE_ENDS = 4;
  localparam int MODE_SET  = 5;

  typedef struct {
    int mode;
    int m;
    int mid_start;
    int en;
    int emin;
    int emax;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs [8];

  jtframe_cen_meter_if #(.W(W)) bus ();

  jtframe_cen_meter #(.W(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int gmin(input int v);
`ifdef JTFRAME_CEN_GAP_EN
    return v;
`else
    return (v == v) ? ALL1 : ALL1;
`endif
  endfunction

  function automatic int gmax(input int v);
`ifdef JTFRAME_CEN_GAP_EN
    return v;
`else
    return (v == v) ? 0 : 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   busy_cnt;
    int   early_valid;
    int   acc;
    int   quiet;
    logic c;
    busy_cnt    = 0;
    early_valid = 0;
    acc         = 0;
    bus.start = 1'b1;
    bus.m     = W'(v.m);
    bus.cen   = 1'b0;
    step();
    for (int k = 0; k < v.m; k++) begin
      if (v.mid_start != 0 && k == v.m / 2) begin
        bus.start = 1'b1;
        bus.m     = W'(5);
      end else begin
        bus.start = 1'b0;
      end
      case (v.mode)
        MODE_ONE:  c = 1'b1;
        MODE_FRAC: begin
          acc = acc + 3;
          if (acc >= 7) begin acc = acc - 7; c = 1'b1; end
          else c = 1'b0;
        end
        MODE_EV4:  c = (k % 4 == 0);
        MODE_ENDS: c = (k == 0) || (k == v.m - 1);
        MODE_SET:  c = (k == 0) || (k == 1) || (k == 4);
        default:   c = 1'b0;
      endcase
      bus.cen = c;
      busy_cnt    += int'(bus.busy);
      early_valid += int'(bus.valid);
      step();
    end
    bus.start = 1'b0;
    bus.cen   = 1'b0;
    chk($sformatf("v%0d_valid_at_t+m+1", idx), int'(bus.valid), 1);
    chk($sformatf("v%0d_busy_in_done", idx), int'(bus.busy), 0);
    chk($sformatf("v%0d_busy_cycles", idx), busy_cnt, v.m);
    chk($sformatf("v%0d_early_valid", idx), early_valid, 0);
    chk($sformatf("v%0d_n", idx), int'(bus.n), v.en);
    chk($sformatf("v%0d_min_gap", idx), int'(bus.min_gap), gmin(v.emin));
    chk($sformatf("v%0d_max_gap", idx), int'(bus.max_gap), gmax(v.emax));
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      quiet += int'(bus.valid) + int'(bus.busy);
      if (i == 3) chk($sformatf("v%0d_n_held", idx), int'(bus.n), v.en);
    end
    chk($sformatf("v%0d_quiet_after", idx), quiet, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_n"},       int'(bus.n), 0);
    chk({tag, "_valid"},   int'(bus.valid), 0);
    chk({tag, "_busy"},    int'(bus.busy), 0);
    chk({tag, "_err"},     int'(bus.err), 0);
    chk({tag, "_min_gap"}, int'(bus.min_gap), ALL1);
    chk({tag, "_max_gap"}, int'(bus.max_gap), 0);
  endtask

  initial begin
    int cnt;
    checks = 0;
    errors = 0;
    vecs[0] = '{MODE_ONE,  16,   0, 16,  1,    1};
    vecs[1] = '{MODE_ZERO, 1023, 0, 0,   ALL1, 0};
    vecs[2] = '{MODE_FRAC, 700,  0, 300, 2,    3};
    vecs[3] = '{MODE_EV4,  20,   0, 5,   4,    4};
    vecs[4] = '{MODE_ONE,  1,    0, 1,   ALL1, 0};
    vecs[5] = '{MODE_ENDS, 1023, 0, 2,   1022, 1022};
    vecs[6] = '{MODE_SET,  8,    0, 3,   1,    3};
    vecs[7] = '{MODE_EV4,  40,   1, 10,  4,    4};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.cen   = 1'b0;
    bus.m     = '0;
    step();
    step();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // m==0 request is rejected with a single err cycle
    bus.start = 1'b1;
    bus.m     = '0;
    step();
    bus.start = 1'b0;
    chk("err_pulse", int'(bus.err), 1);
    chk("err_busy", int'(bus.busy), 0);
    step();
    chk("err_one_cycle", int'(bus.err), 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cnt += int'(bus.valid) + int'(bus.busy);
      step();
    end
    chk("err_no_window", cnt, 0);

    // start held during DONE must not open a new window
    bus.start = 1'b1;
    bus.m     = W'(2);
    bus.cen   = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.start = 1'b1;
    bus.m     = W'(3);
    chk("done_start_valid", int'(bus.valid), 1);
    chk("done_start_n", int'(bus.n), 2);
    step();
    bus.start = 1'b0;
    bus.cen   = 1'b0;
    chk("done_start_ignored", int'(bus.busy), 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt += int'(bus.valid) + int'(bus.busy);
    end
    chk("done_start_quiet", cnt, 0);

    // reset in the middle of a window aborts it
    bus.start = 1'b1;
    bus.m     = W'(100);
    bus.cen   = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_abort_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    step();
    step();
    chk_reset_outputs("abort_hold");
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 110; i++) begin
      step();
      cnt += int'(bus.valid) + int'(bus.busy);
    end
    chk("abort_no_valid", cnt, 0);
    bus.cen = 1'b0;
    run_vec(vecs[0], 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtframe_cen_meter.md
JTFRAME_CEN_METER -- requirements
Module: jtframe_cen_meter

Interface
REQ-001 SHALL have parameter W, default 10: width of window, count and gap fields, matching the 10-bit n/m ratio fields of the fractional cen generator.
REQ-002 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have port cen  input  1: clock-enable stream under measurement, sampled on clk.
REQ-005 SHALL have port start  input  1: measurement request; sampled only in IDLE.
REQ-006 SHALL have port m  input  W: window length in clk cycles (denominator); captured when start is accepted.
REQ-007 SHALL have port n  output  W: count of cen pulses in the last completed window (numerator).
REQ-008 SHALL have port valid  output  1: one-cycle pulse; n, min_gap and max_gap are updated in the same cycle.
REQ-009 SHALL have port busy  output  1: high while in MEASURE.
REQ-010 SHALL have port err  output  1: one-cycle pulse when start is rejected because m==0.
REQ-011 SHALL have port min_gap  output  W: smallest clk-cycle distance between consecutive cen pulses in the last window.
REQ-012 SHALL have port max_gap  output  W: largest such distance.

Function
REQ-013 SHALL implement the states IDLE, MEASURE and DONE.
REQ-014 IDLE: start=1 with m!=0 SHALL capture m, clear the working counters and go to MEASURE; start=1 with m==0 SHALL pulse err for one cycle and stay in IDLE.
REQ-015 MEASURE SHALL last exactly m cycles; cen SHALL be sampled in each of those cycles (the m cycles after the accept cycle) and the working count incremented per sampled 1.
REQ-016 The working count SHALL never exceed m, because at most one pulse is counted per cycle; no saturation logic is required.
REQ-017 After the m-th MEASURE cycle the block SHALL enter DONE for one cycle.
REQ-018 In DONE the block SHALL assert valid, register the results to n, min_gap and max_gap, and then return to IDLE.
REQ-019 Latency: start accepted at cycle t -> valid asserted at cycle t+m+1.
REQ-020 The outputs n, min_gap and max_gap SHALL hold their values until the next DONE.
REQ-021 A start asserted while in MEASURE or DONE SHALL be ignored and not queued; the m input SHALL be ignored outside the accept cycle.
REQ-022 A start asserted in the same cycle that DONE returns to IDLE SHALL be ignored; start is evaluated only while the state is IDLE.
REQ-023 busy SHALL be high exactly during the m MEASURE cycles.

Reset
REQ-024 While rst_n=0 the block SHALL be in state IDLE.
REQ-025 While rst_n=0 the outputs SHALL be: n=0, valid=0, busy=0, err=0, min_gap=all ones, max_gap=0.
REQ-026 While rst_n=0 all internal counters SHALL be 0.
REQ-027 Reset asserted during MEASURE SHALL abort the measurement immediately, with no valid pulse, and SHALL leave the outputs at their reset values.

Configuration
REQ-028 The macro JTFRAME_CEN_GAP_EN, when defined, SHALL enable gap tracking.
REQ-029 Gap tracking: a gap counter SHALL start at the first cen of the window and measure the cycles between successive sampled cen pulses.
REQ-030 The gap counter SHALL saturate at all ones.
REQ-031 Each completed gap SHALL update the working minimum and maximum.
REQ-032 If fewer than two pulses occur in a window, DONE SHALL report min_gap=all ones and max_gap=0.
REQ-033 Without JTFRAME_CEN_GAP_EN, no gap logic SHALL be built, min_gap SHALL be constant all ones and max_gap SHALL be constant 0.

Verification
REQ-034 Scenario: cen driven by a 3/7 fractional generator, m=700 -> valid at t+701, n=300, min_gap=2, max_gap=3 (GAP_EN).
REQ-035 Scenario: cen held at 1, m=16 -> n=16, min_gap=max_gap=1, busy high for exactly 16 cycles.
REQ-036 Scenario: cen held at 0, m=1023 -> n=0, min_gap=1023, max_gap=0, one valid pulse.
REQ-037 Scenario: start with m=0 -> err for 1 cycle, busy stays 0, no valid; a second start issued mid-window -> ignored, only one valid.
REQ-038 Scenario: rst_n pulled low 5 cycles into a window of m=100 -> no valid; all outputs at reset values; a fresh start afterwards completes normally.
REQ-039 Scenario: build without JTFRAME_CEN_GAP_EN, cen held at 1, m=16 -> n=16, min_gap=1023, max_gap=0.
